// File: rtl/tetris_pkg.sv
// Shared board geometry, FSM state encoding and anchor-index helper for the
// falling-piece controller.
package tetris_pkg;

    localparam int BOARD_W   = 20;
    localparam int BOARD_H   = 25;
    localparam int MASK_DIM  = 4;
    localparam int MASK_BITS = MASK_DIM * MASK_DIM;
    localparam int CELLS     = BOARD_W * BOARD_H;
    localparam int CELL_W    = $clog2(CELLS);
    localparam int ROW_W     = 5;
    localparam int COL_W     = 5;

    // One bit wider than a cell index so row/col sums past the board edge
    // can never wrap onto a legal cell.
    localparam int IDX_W = 10;

    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(BOARD_H - 1);
    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(BOARD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        SETTLE,
        SPAWN_CHK,
        FALL,
        LOCK,
        CLEAR_WAIT,
        OVER
    } fall_state_e;

    function automatic logic [IDX_W-1:0] anchor_idx(input logic [IDX_W-1:0] row,
                                                   input logic [IDX_W-1:0] col);
        return row * IDX_W'(BOARD_W) + col;
    endfunction

endpackage

// File: rtl/fall_ctrl_if.sv
// Handshake bundle between the falling-piece controller and its neighbours
// (piece generator, board store, line-clear block).
interface fall_ctrl_if;
    import tetris_pkg::*;

    logic                 start;
    logic                 tick;
    logic                 btn_left;
    logic                 btn_right;
    logic                 btn_rot;
    logic                 btn_down;
    logic [MASK_BITS-1:0] enable_moving;
    logic [CELLS-1:0]     enable_little;
    logic                 clear_done;
    logic [CELL_W-1:0]    little_square_num;
    logic                 loading_square;
    logic                 rotate_r;
    logic                 lock_piece;
    logic                 game_over;

    modport master (
        output start, tick, btn_left, btn_right, btn_rot, btn_down,
        output enable_moving, enable_little, clear_done,
        input  little_square_num, loading_square, rotate_r, lock_piece, game_over
    );

    modport slave (
        input  start, tick, btn_left, btn_right, btn_rot, btn_down,
        input  enable_moving, enable_little, clear_done,
        output little_square_num, loading_square, rotate_r, lock_piece, game_over
    );

endinterface

// File: rtl/fall_collide.sv
// Purely combinational collision test of a 4x4 piece mask placed at a
// candidate anchor against the board edges and the occupied-cell map.
module fall_collide
    import tetris_pkg::*;
(
    input  logic [MASK_BITS-1:0] mask_i,
    input  logic [CELLS-1:0]     board_i,
    input  logic [ROW_W-1:0]     row_i,
    input  logic [COL_W-1:0]     col_i,
    output logic                 hit_o
);

    logic [IDX_W-1:0] row_sum;
    logic [IDX_W-1:0] col_sum;

    // NOTE: every variable written here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit_o   = 1'b0;
        row_sum = '0;
        col_sum = '0;
        for (int r = 0; r < MASK_DIM; r++) begin
            for (int c = 0; c < MASK_DIM; c++) begin
                row_sum = IDX_W'(row_i) + IDX_W'(r);
                col_sum = IDX_W'(col_i) + IDX_W'(c);
                if (mask_i[r*MASK_DIM + c]) begin
                    if (row_sum > ROW_LAST || col_sum > COL_LAST) begin
                        hit_o = 1'b1;
                    end else if (board_i[CELL_W'(anchor_idx(row_sum, col_sum))]) begin
                        hit_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fall_ctrl.sv
// Falling-piece controller: spawn, gravity/user moves, lock and game over.
// Define FALL_CTRL_SOFT_DROP_EN to make btn_down an extra down-move trigger.
module fall_ctrl
    import tetris_pkg::*;
#(
    parameter int SPAWN_COL  = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    fall_ctrl_if.slave  bus
);

    fall_state_e       state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [CELL_W-1:0] lsn_q, lsn_d;
    logic [2:0]        settle_q, settle_d;
    logic [1:0]        rot_hold_q, rot_hold_d;
    logic              load_q, load_d;
    logic              rot_q, rot_d;
    logic              lock_q, lock_d;
    logic              over_q, over_d;

    logic [ROW_W-1:0]  cand_row;
    logic [COL_W-1:0]  cand_col;
    logic              cand_hit;
    logic              down_req;

`ifdef FALL_CTRL_SOFT_DROP_EN
    assign down_req = bus.tick | bus.btn_down;
`else
    logic btn_down_unused;
    assign btn_down_unused = bus.btn_down;
    assign down_req        = bus.tick;
`endif

    // Single checker shared by the spawn check and every move candidate.
    fall_collide u_collide (
        .mask_i  (bus.enable_moving),
        .board_i (bus.enable_little),
        .row_i   (cand_row),
        .col_i   (cand_col),
        .hit_o   (cand_hit)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        settle_d   = settle_q;
        rot_hold_d = (rot_hold_q != 2'd0) ? rot_hold_q - 2'd1 : 2'd0;
        load_d     = 1'b0;
        rot_d      = 1'b0;
        lock_d     = 1'b0;
        cand_row   = row_q;
        cand_col   = col_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = SPAWN;
            end
            SPAWN: begin
                row_d    = '0;
                col_d    = COL_W'(SPAWN_COL);
                settle_d = '0;
                load_d   = 1'b1;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == 3'(SETTLE_CYC - 1)) begin
                    settle_d = '0;
                    state_d  = SPAWN_CHK;
                end else begin
                    settle_d = settle_q + 3'd1;
                end
            end
            SPAWN_CHK: begin
                state_d = cand_hit ? OVER : FALL;
            end
            FALL: begin
                // Fixed priority; losing events in this cycle are simply dropped.
                if (down_req) begin
                    cand_row = row_q + ROW_W'(1);
                    if (cand_hit) state_d = LOCK;
                    else          row_d   = cand_row;
                end else if (bus.btn_left) begin
                    if (col_q != '0) begin
                        cand_col = col_q - COL_W'(1);
                        if (!cand_hit) col_d = cand_col;
                    end
                end else if (bus.btn_right) begin
                    cand_col = col_q + COL_W'(1);
                    if (!cand_hit) col_d = cand_col;
                end else if (bus.btn_rot && rot_hold_q == 2'd0) begin
                    rot_d      = 1'b1;
                    rot_hold_d = 2'd2;
                end
            end
            LOCK: begin
                lock_d  = 1'b1;
                state_d = CLEAR_WAIT;
            end
            CLEAR_WAIT: begin
                if (bus.clear_done) state_d = SPAWN;
            end
            OVER: begin
                if (bus.start) begin
                    row_d   = '0;
                    col_d   = COL_W'(SPAWN_COL);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        over_d = (state_d == OVER);
        lsn_d  = CELL_W'(anchor_idx(IDX_W'(row_d), IDX_W'(col_d)));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and the update order inside the block does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= COL_W'(SPAWN_COL);
            lsn_q      <= CELL_W'(SPAWN_COL);
            settle_q   <= '0;
            rot_hold_q <= '0;
            load_q     <= 1'b0;
            rot_q      <= 1'b0;
            lock_q     <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            lsn_q      <= lsn_d;
            settle_q   <= settle_d;
            rot_hold_q <= rot_hold_d;
            load_q     <= load_d;
            rot_q      <= rot_d;
            lock_q     <= lock_d;
            over_q     <= over_d;
        end
    end

    assign bus.little_square_num = lsn_q;
    assign bus.loading_square    = load_q;
    assign bus.rotate_r          = rot_q;
    assign bus.lock_piece        = lock_q;
    assign bus.game_over         = over_q;

endmodule

// File: tb/tb_fall_ctrl.sv
// Scoreboard bench for fall_ctrl: directed moves push expected output events,
// a negedge monitor pops and compares every event the controller presents.
module tb_fall_ctrl;
    import tetris_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fall_ctrl_if bus ();

    fall_ctrl #(.SPAWN_COL(8), .SETTLE_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum int {EV_POS, EV_LOAD, EV_ROT, EV_LOCK, EV_OVER} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       val;
    } ev_t;

    localparam int P_START = 1;
    localparam int P_TICK  = 2;
    localparam int P_LEFT  = 4;
    localparam int P_RIGHT = 8;
    localparam int P_ROT   = 16;
    localparam int P_DOWN  = 32;
    localparam int P_CLEAR = 64;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic expect_ev(input ev_kind_e k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Events are encoded as kind*1000+value so one comparison covers both.
    task automatic observe(input ev_kind_e k, input int v);
        ev_t e;
        if (exp_q.size() == 0) begin
            check($sformatf("spurious %s event", k.name()), v, -1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("event %s(%0d)", e.kind.name(), e.val),
                  int'(k) * 1000 + v, int'(e.kind) * 1000 + e.val);
        end
    endtask

    int   prev_lsn;
    logic prev_go;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_lsn = int'(bus.little_square_num);
            prev_go  = bus.game_over;
        end else begin
            if (int'(bus.little_square_num) != prev_lsn) begin
                prev_lsn = int'(bus.little_square_num);
                observe(EV_POS, prev_lsn);
            end
            if (bus.loading_square) observe(EV_LOAD, 0);
            if (bus.rotate_r)       observe(EV_ROT, 0);
            if (bus.lock_piece)     observe(EV_LOCK, 0);
            if (bus.game_over !== prev_go) begin
                prev_go = bus.game_over;
                observe(EV_OVER, int'(bus.game_over));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int m, input int gap = 1);
        bus.start      = (m & P_START) != 0;
        bus.tick       = (m & P_TICK)  != 0;
        bus.btn_left   = (m & P_LEFT)  != 0;
        bus.btn_right  = (m & P_RIGHT) != 0;
        bus.btn_rot    = (m & P_ROT)   != 0;
        bus.btn_down   = (m & P_DOWN)  != 0;
        bus.clear_done = (m & P_CLEAR) != 0;
        cyc(1);
        bus.start      = 1'b0;
        bus.tick       = 1'b0;
        bus.btn_left   = 1'b0;
        bus.btn_right  = 1'b0;
        bus.btn_rot    = 1'b0;
        bus.btn_down   = 1'b0;
        bus.clear_done = 1'b0;
        cyc(gap);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start         = 1'b0;
        bus.tick          = 1'b0;
        bus.btn_left      = 1'b0;
        bus.btn_right     = 1'b0;
        bus.btn_rot       = 1'b0;
        bus.btn_down      = 1'b0;
        bus.clear_done    = 1'b0;
        bus.enable_moving = 16'h0720;
        bus.enable_little = '0;

        cyc(3);
        check("reset little_square_num", int'(bus.little_square_num), 8);
        check("reset loading_square", int'(bus.loading_square), 0);
        check("reset rotate_r", int'(bus.rotate_r), 0);
        check("reset lock_piece", int'(bus.lock_piece), 0);
        check("reset game_over", int'(bus.game_over), 0);
        rst_n = 1'b1;
        cyc(2);

        // Spawn on an empty board, then a start in FALL must do nothing.
        expect_ev(EV_LOAD, 0);
        pulse(P_START);
        cyc(5);
        check("spawn anchor in FALL", int'(bus.little_square_num), 8);
        check("spawn game_over", int'(bus.game_over), 0);
        pulse(P_START);

        // Left to the wall; the ninth press is rejected at col 0.
        for (int i = 1; i <= 8; i++) begin
            expect_ev(EV_POS, 8 - i);
            pulse(P_LEFT);
        end
        pulse(P_LEFT);
        check("left wall", int'(bus.little_square_num), 0);

        // Right to col 17 (mask is 3 wide); the next press hits the edge.
        for (int i = 1; i <= 17; i++) begin
            expect_ev(EV_POS, i);
            pulse(P_RIGHT);
        end
        pulse(P_RIGHT);
        check("right wall", int'(bus.little_square_num), 17);

        // Tick wins over left in the same cycle.
        expect_ev(EV_POS, 37);
        pulse(P_TICK | P_LEFT);

        // Rotate holdoff: three back-to-back presses give one pulse.
        expect_ev(EV_ROT, 0);
        pulse(P_ROT, 0);
        pulse(P_ROT, 0);
        pulse(P_ROT, 0);
        cyc(2);
        expect_ev(EV_ROT, 0);
        pulse(P_ROT);

        // Gravity down to the floor; mask bottom row sits two below the anchor.
        for (int row = 2; row <= 22; row++) begin
            expect_ev(EV_POS, row * 20 + 17);
            pulse(P_TICK);
        end
        check("floor anchor", int'(bus.little_square_num), 457);
        expect_ev(EV_LOCK, 0);
        pulse(P_TICK);
        for (int i = 0; i < 7; i++) pulse(P_TICK);
        pulse(P_LEFT);
        expect_ev(EV_POS, 8);
        expect_ev(EV_LOAD, 0);
        pulse(P_CLEAR);
        cyc(5);

        // Land on an obstacle at row 6, cols 8..11.
        bus.enable_little[131:128] = 4'hF;
        for (int row = 1; row <= 3; row++) begin
            expect_ev(EV_POS, row * 20 + 8);
            pulse(P_TICK);
        end
        expect_ev(EV_LOCK, 0);
        pulse(P_TICK);
        check("obstacle anchor", int'(bus.little_square_num), 68);
        expect_ev(EV_POS, 8);
        expect_ev(EV_LOAD, 0);
        pulse(P_CLEAR);
        cyc(5);

        // Block the spawn area (row 2, cols 8..11): lock, respawn, game over.
        bus.enable_little         = '0;
        bus.enable_little[51:48]  = 4'hF;
        expect_ev(EV_LOCK, 0);
        pulse(P_TICK);
        expect_ev(EV_LOAD, 0);
        expect_ev(EV_OVER, 1);
        pulse(P_CLEAR);
        cyc(6);
        check("game_over set", int'(bus.game_over), 1);
        pulse(P_TICK);
        expect_ev(EV_OVER, 0);
        pulse(P_START);
        check("game_over cleared", int'(bus.game_over), 0);
        check("anchor after over", int'(bus.little_square_num), 8);

        // Reset while falling abandons the piece without a lock pulse.
        bus.enable_little = '0;
        expect_ev(EV_LOAD, 0);
        pulse(P_START);
        cyc(5);
        expect_ev(EV_POS, 28);
        pulse(P_TICK);
`ifdef FALL_CTRL_SOFT_DROP_EN
        expect_ev(EV_POS, 48);
`endif
        pulse(P_DOWN);
        rst_n = 1'b0;
        cyc(2);
        check("mid-fall reset anchor", int'(bus.little_square_num), 8);
        rst_n = 1'b1;
        cyc(10);
        pulse(P_TICK);
        cyc(3);
        check("idle after reset anchor", int'(bus.little_square_num), 8);
        check("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
